mux8way16_collector: RTL and testbench
======================================

Name: mux8way16_collector

Overview:
8-to-1 collector, the return-path counterpart of the 8-way demux fabric: gathers words from 8 source channels into a single output stream. Each source and the sink use valid/ready handshakes. A round-robin arbiter chooses the source, and one output register holds the word. The chosen source index is reported on out_sel using the same 3-bit encoding as the demux select (000=a … 111=h), so a downstream dmux8way can route a response back to the same channel.

Parameters:
WIDTH, 16, data word width (Hack word).

Ports:
clk  input  1  single clock, all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  8  per-source valid; bit i = channel i (a=0 … h=7).
in_data  input  8*WIDTH  packed source data; channel i at bits [i*WIDTH +: WIDTH].
in_ready  output  8  per-source accept strobe; one-hot or zero.
out_valid  output  1  output register holds a word.
out_data  output  WIDTH  registered output word.
out_sel  output  3  index of the source that produced out_data.
out_ready  input  1  sink accepts the word this cycle.

Behaviour:
- Reset (synchronous, active-high): out_valid=0, out_data=0, out_sel=000, rr pointer ptr=0. While reset=1, in_ready=8'h00 regardless of inputs.
- load = ~out_valid | out_ready. The output register can take a new word this cycle.
- Arbitration is combinational. Scan channels ptr, ptr+1, … ptr+7 (mod 8). The grant is the first channel with in_valid=1.
- in_ready = onehot(grant) when load=1 and |in_valid=1. Otherwise in_ready=0. At most one bit is set. in_ready must not depend on in_data.
- Source transfer on channel g: in_valid[g] & in_ready[g]. At that edge:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
  - ptr <= g+1 mod 8 (7 wraps to 0).
- Sink transfer: out_valid & out_ready. If there is no simultaneous source transfer, out_valid <= 0, and out_data/out_sel keep their last value.
- Simultaneous sink and source transfer in the same cycle: the register reloads with the new word and out_valid stays 1. This gives full throughput of 1 word/cycle.
- Latency: 1 cycle from source transfer to out_valid=1 with that word.
- Backpressure: while out_valid=1 and out_ready=0, out_data/out_sel/out_valid stay stable, in_ready=0, and ptr is unchanged.
- No source valid: in_ready=0, ptr unchanged, and out_valid drains normally.
- ptr advances only on a source transfer, never on idle cycles. Fairness: any continuously valid channel is granted within 8 source transfers.
- Sources may drop in_valid without a transfer. The arbiter re-evaluates every cycle, with no lock-in.
- Reset mid-operation: a word held in the output register is discarded. Any source transfer in the reset cycle is ignored, since in_ready=0.
- No storage beyond the single output register; there is no skid buffer.

Test Plan:
1. Reset while out_valid=1 and out_data=16'hBEEF, then release. Required: out_valid=0, out_data=0, out_sel=000, in_ready=00. Then drive only ch0 valid; the first grant goes to ch0.
2. Only ch5 valid with in_data[5]=16'h1234, out_ready=1. Required: in_ready=8'b0010_0000 in cycle 0. In cycle 1, out_valid=1, out_data=16'h1234, out_sel=101. The next grant search starts at ch6.
3. All 8 channels valid with data 16'h00i0, out_ready=1 continuously. Required: out_sel sequence 0,1,…,7,0 on consecutive cycles with out_data matching, and no bubble cycles.
4. out_ready=0 for 4 cycles while holding ch2 data 16'hA5A5. Required: out_valid=1, out_data=16'hA5A5 and out_sel=010 stay stable, and in_ready=00 throughout. When out_ready rises with ch3 valid, ch3 is accepted in that same cycle.
5. Wrap: the last grant was ch6; ch7 and ch0 are valid. Required: ch7 is granted, then ch0, then ptr=1.
6. Only ch1 and ch4 valid with sources always valid. Required: grants alternate 1,4,1,4. ptr does not move on idle cycles inserted by deasserting both valids.

Source files
------------

// File: rtl/mux8way16_collector.sv
// mux8way16_collector: 8-to-1 round-robin collector feeding a single registered output.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   reset      - synchronous, active-high reset
//   in_valid   - per-source valid, bit i = channel i (a=0 .. h=7)
//   in_data    - packed source words, channel i at [i*WIDTH +: WIDTH]
//   in_ready   - per-source accept strobe, one-hot or zero
//   out_valid  - output register holds a word
//   out_data   - registered output word
//   out_sel    - index of the source that produced out_data (demux select encoding)
//   out_ready  - sink accepts the word this cycle
module mux8way16_collector #(
   parameter int unsigned WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         in_valid,
   input  logic [8*WIDTH-1:0] in_data,
   output logic [7:0]         in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [2:0]         out_sel,
   input  logic               out_ready
);

   logic [2:0]       ptr_q, ptr_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [2:0]       out_sel_q, out_sel_d;

   logic             load;
   logic [15:0]      valid_dbl;
   logic [7:0]       valid_rot;
   logic [2:0]       grant_off;
   logic [2:0]       grant_idx;
   logic             grant_found;
   logic             src_xfer;

   // Output register can accept a word when empty or being drained this cycle.
   assign load = ~out_valid_q | out_ready;

   // Rotate so that bit 0 of valid_rot is channel ptr_q; the lowest set bit wins.
   assign valid_dbl = {in_valid, in_valid} >> ptr_q;
   assign valid_rot = valid_dbl[7:0];

   always_comb begin
      grant_off   = 3'd0;
      grant_found = 1'b0;
      for (int k = 7; k >= 0; k--) begin
         if (valid_rot[k]) begin
            grant_off   = 3'(k);
            grant_found = 1'b1;
         end
      end
   end

   // 3-bit addition wraps modulo 8 naturally.
   assign grant_idx = ptr_q + grant_off;

   assign src_xfer = grant_found & load & ~reset;

   always_comb begin
      in_ready = 8'h00;
      if (src_xfer) begin
         in_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      if (src_xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data[32'(grant_idx) * WIDTH +: WIDTH];
         out_sel_d   = grant_idx;
         ptr_d       = grant_idx + 3'd1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q       <= 3'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= 3'd0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux8way16_collector.sv
module tb_mux8way16_collector;

   localparam int W = 16;

   logic           clk;
   logic           reset;
   logic [7:0]     in_valid;
   logic [8*W-1:0] in_data;
   logic [7:0]     in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [2:0]     out_sel;
   logic           out_ready;

   int n_checks;
   int n_fail;

   // Reference model: a pointer, and a one-word holding register.
   int          m_ptr;
   bit          m_valid;
   logic [W-1:0] m_data;
   int          m_sel;

   mux8way16_collector #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [W-1:0] chan_data(input int ch);
      return in_data[ch*W +: W];
   endfunction

   task automatic set_data(input int ch, input logic [W-1:0] v);
      in_data[ch*W +: W] = v;
   endtask

   // First valid channel scanning ptr, ptr+1, ... mod 8; -1 if nothing may be granted.
   function automatic int model_grant();
      if (reset) return -1;
      if (m_valid && !out_ready) return -1;
      for (int k = 0; k < 8; k++) begin
         if (in_valid[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
      end
      return -1;
   endfunction

   function automatic logic [7:0] model_ready();
      int g;
      logic [7:0] r;
      g = model_grant();
      r = 8'h00;
      if (g >= 0) r = 8'(1 << g);
      return r;
   endfunction

   // Advance one clock, updating the model from the inputs present before the edge.
   task automatic tick();
      int g;
      logic [W-1:0] d;
      bit rs;
      rs = reset;
      g  = model_grant();
      if (g >= 0) d = chan_data(g);
      else d = '0;
      @(posedge clk);
      if (rs) begin
         m_ptr = 0; m_valid = 0; m_data = '0; m_sel = 0;
      end else if (g >= 0) begin
         m_valid = 1; m_data = d; m_sel = g; m_ptr = (g + 1) % 8;
      end else if (m_valid && out_ready) begin
         m_valid = 0;
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 8'h00;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      in_valid = 8'h01; set_data(0, 16'hBEEF); out_ready = 1'b0; reset = 1'b0;
      tick();
      if (out_valid !== 1'b1 || out_data !== 16'hBEEF) begin
         $display("FAIL reset_preload: valid=%b data=%h required 1 beef", out_valid, out_data);
         n_fail++;
      end
      n_checks++;
      reset = 1'b1; in_valid = 8'hFF; #1;
      if (in_ready !== 8'h00) begin
         $display("FAIL reset_in_ready: got %h required 00", in_ready); n_fail++;
      end
      n_checks++;
      tick();
      reset = 1'b0; in_valid = 8'h00; #1;
      if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_sel !== 3'b000
          || in_ready !== 8'h00) begin
         $display("FAIL reset_state: v=%b d=%h s=%0d r=%h required 0 0000 0 00",
                  out_valid, out_data, out_sel, in_ready);
         n_fail++;
      end
      n_checks++;
      in_valid = 8'h01; #1;
      if (in_ready !== 8'h01) begin
         $display("FAIL reset_first_grant: got %h required 01", in_ready); n_fail++;
      end
      n_checks++;
      tick();
   endtask

   task automatic test_single_channel();
      out_ready = 1'b1; in_valid = 8'h20; set_data(5, 16'h1234); #1;
      if (in_ready !== 8'b0010_0000) begin
         $display("FAIL single_ready: got %b required 00100000", in_ready); n_fail++;
      end
      n_checks++;
      tick();
      if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_sel !== 3'b101) begin
         $display("FAIL single_out: v=%b d=%h s=%b required 1 1234 101",
                  out_valid, out_data, out_sel);
         n_fail++;
      end
      n_checks++;
      // Search now starts at ch6, so ch0 beats ch5.
      in_valid = 8'h21; #1;
      if (in_ready !== 8'h01) begin
         $display("FAIL single_next_search: got %h required 01", in_ready); n_fail++;
      end
      n_checks++;
      tick();
   endtask

   task automatic test_back_to_back();
      do_reset();
      out_ready = 1'b1; in_valid = 8'hFF;
      for (int i = 0; i < 8; i++) set_data(i, 16'(i << 4));
      for (int k = 0; k < 9; k++) begin
         #1;
         if (in_ready !== 8'(1 << (k % 8))) begin
            $display("FAIL b2b_ready[%0d]: got %h required %h", k, in_ready, 8'(1 << (k % 8)));
            n_fail++;
         end
         n_checks++;
         tick();
         if (out_valid !== 1'b1 || out_sel !== 3'(k % 8) || out_data !== 16'((k % 8) << 4)) begin
            $display("FAIL b2b_out[%0d]: v=%b s=%0d d=%h required 1 %0d %h", k, out_valid,
                     out_sel, out_data, k % 8, 16'((k % 8) << 4));
            n_fail++;
         end
         n_checks++;
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b1; in_valid = 8'h04; set_data(2, 16'hA5A5); set_data(3, 16'h3333);
      tick();
      out_ready = 1'b0; in_valid = 8'h0C;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (out_valid !== 1'b1 || out_data !== 16'hA5A5 || out_sel !== 3'b010
             || in_ready !== 8'h00) begin
            $display("FAIL bp_hold[%0d]: v=%b d=%h s=%b r=%h required 1 a5a5 010 00", k,
                     out_valid, out_data, out_sel, in_ready);
            n_fail++;
         end
         n_checks++;
         tick();
      end
      out_ready = 1'b1; in_valid = 8'h08; #1;
      if (in_ready !== 8'h08) begin
         $display("FAIL bp_release_ready: got %h required 08", in_ready); n_fail++;
      end
      n_checks++;
      tick();
      if (out_valid !== 1'b1 || out_data !== 16'h3333 || out_sel !== 3'b011) begin
         $display("FAIL bp_release_out: v=%b d=%h s=%b required 1 3333 011",
                  out_valid, out_data, out_sel);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_wrap();
      do_reset();
      out_ready = 1'b1; in_valid = 8'h40;
      tick();
      in_valid = 8'h81; #1;
      if (in_ready !== 8'h80) begin
         $display("FAIL wrap_ch7: got %h required 80", in_ready); n_fail++;
      end
      n_checks++;
      tick();
      #1;
      if (in_ready !== 8'h01) begin
         $display("FAIL wrap_ch0: got %h required 01", in_ready); n_fail++;
      end
      n_checks++;
      tick();
      // ptr=1: ch1 must win over ch0 and ch7.
      in_valid = 8'h83; #1;
      if (in_ready !== 8'h02) begin
         $display("FAIL wrap_ptr1: got %h required 02", in_ready); n_fail++;
      end
      n_checks++;
      tick();
   endtask

   task automatic test_two_channels();
      logic [7:0] seq [4];
      seq[0] = 8'h02; seq[1] = 8'h10; seq[2] = 8'h02; seq[3] = 8'h10;
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_valid = 8'h12; #1;
         if (in_ready !== seq[k]) begin
            $display("FAIL alt_grant[%0d]: got %h required %h", k, in_ready, seq[k]);
            n_fail++;
         end
         n_checks++;
         tick();
         // Idle gap after each grant must not move the pointer.
         in_valid = 8'h00;
         for (int j = 0; j < 2; j++) begin
            #1;
            if (in_ready !== 8'h00) begin
               $display("FAIL alt_idle[%0d]: got %h required 00", k, in_ready); n_fail++;
            end
            n_checks++;
            tick();
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] exp_r;
      for (int c = 0; c < 400; c++) begin
         in_valid  = 8'($urandom);
         if ($urandom_range(0, 5) == 0) in_valid = 8'h00;
         for (int i = 0; i < 8; i++) set_data(i, 16'($urandom));
         out_ready = ($urandom_range(0, 3) != 0);
         reset     = ($urandom_range(0, 40) == 0);
         #1;
         exp_r = model_ready();
         if (in_ready !== exp_r || out_valid !== m_valid || out_data !== m_data
             || out_sel !== 3'(m_sel)) begin
            $display("FAIL rand[%0d]: r=%h v=%b d=%h s=%0d required r=%h v=%b d=%h s=%0d", c,
                     in_ready, out_valid, out_data, out_sel, exp_r, m_valid, m_data, m_sel);
            n_fail++;
         end
         n_checks++;
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      m_ptr = 0; m_valid = 0; m_data = '0; m_sel = 0;
      reset = 1'b1; in_valid = 8'h00; in_data = '0; out_ready = 1'b0;
      #1;
      tick();
      tick();
      reset = 1'b0;
      test_reset();
      test_single_channel();
      test_back_to_back();
      test_backpressure();
      test_wrap();
      test_two_channels();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
